// File: rtl/tx_frame_if.sv
// Word-in / bit-out handshake bundle between the payload feeder, the frame
// serializer and the Manchester encoder.
interface tx_frame_if #(
  parameter int DATA_W = 16
);
  logic              tx_en;
  logic [DATA_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;
  logic              bit_out;
  logic              bit_valid;
  logic              bit_ready;
  logic              frame_busy;
  logic              frame_done;

  // Serializer side: takes words and encoder readiness, produces the bit stream.
  modport slave (
    input  tx_en, word_data, word_valid, bit_ready,
    output word_ready, bit_out, bit_valid, frame_busy, frame_done
  );

  // Feeder/encoder side.
  modport master (
    output tx_en, word_data, word_valid, bit_ready,
    input  word_ready, bit_out, bit_valid, frame_busy, frame_done
  );
endinterface

// File: rtl/tx_frame_serializer.sv
// Wraps payload words as [SYNC | PAYLOAD | CRC-8] and streams them MSB first,
// one bit per encoder handshake, with idle fill between frames.
module tx_frame_serializer #(
   parameter int                DATA_W   = 16,
   parameter int                SYNC_W   = 8,
   parameter logic [SYNC_W-1:0] SYNC_PAT = 8'hD5,
   parameter logic              IDLE_BIT = 1'b0
) (
   input  logic       clk_sys,
   input  logic       rst_n,
   tx_frame_if.slave  bus
);

   localparam int MAX_W = (DATA_W > SYNC_W) ? ((DATA_W > 8) ? DATA_W : 8)
                                            : ((SYNC_W > 8) ? SYNC_W : 8);
   localparam int IDX_W = $clog2(MAX_W);

   typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_CRC} state_t;

   state_t            r_state;
   logic [IDX_W-1:0]  r_idx;
   logic [7:0]        r_crc;
   logic [DATA_W-1:0] r_shreg;
   logic              r_bit_out;
   logic              r_bit_valid;
   logic              r_frame_busy;
   logic              r_frame_done;

   logic              w_bh;
   logic              w_accept;
   logic              w_word_ready;
   logic [SYNC_W-1:0] w_sync_sh;
   logic [DATA_W-1:0] w_data_sh;
   logic [7:0]        w_crc_sh;

   // MSB-first CRC-8, poly 0x07, one message bit per call.
   function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
      return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
   endfunction

   assign w_bh         = r_bit_valid & bus.bit_ready;
   assign w_word_ready = bus.tx_en & r_bit_valid & (r_state == S_IDLE);
   assign w_accept     = w_word_ready & bus.word_valid;

   // Shift-based bit selects keep the index width independent of each field width.
   assign w_sync_sh = SYNC_PAT >> r_idx;
   assign w_data_sh = r_shreg >> r_idx;
   assign w_crc_sh  = r_crc >> r_idx;

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_idx        <= '0;
         r_crc        <= 8'h00;
         r_shreg      <= '0;
         r_bit_out    <= IDLE_BIT;
         r_bit_valid  <= 1'b0;
         r_frame_busy <= 1'b0;
         r_frame_done <= 1'b0;
      end else if (!bus.tx_en) begin
         // Flush: the frame in flight is abandoned, never resumed.
         r_state      <= S_IDLE;
         r_idx        <= '0;
         r_crc        <= 8'h00;
         r_shreg      <= '0;
         r_bit_out    <= IDLE_BIT;
         r_bit_valid  <= 1'b0;
         r_frame_busy <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_bit_valid  <= 1'b1;
         r_frame_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               // The bit already offered completes before the frame starts.
               if (w_bh) r_bit_out <= IDLE_BIT;
               if (w_accept) begin
                  r_shreg      <= bus.word_data;
                  r_crc        <= 8'h00;
                  r_idx        <= IDX_W'(SYNC_W - 1);
                  r_state      <= S_SYNC;
                  r_frame_busy <= 1'b1;
               end
            end
            S_SYNC: if (w_bh) begin
               r_bit_out <= w_sync_sh[0];
               if (r_idx == '0) begin
                  r_idx   <= IDX_W'(DATA_W - 1);
                  r_state <= S_DATA;
               end else begin
                  r_idx <= r_idx - 1'b1;
               end
            end
            S_DATA: if (w_bh) begin
               r_bit_out <= w_data_sh[0];
               r_crc     <= crc8_step(r_crc, w_data_sh[0]);
               if (r_idx == '0) begin
                  r_idx   <= IDX_W'(7);
                  r_state <= S_CRC;
               end else begin
                  r_idx <= r_idx - 1'b1;
               end
            end
            S_CRC: if (w_bh) begin
               r_bit_out <= w_crc_sh[0];
               if (r_idx == '0) begin
                  r_state      <= S_IDLE;
                  r_frame_busy <= 1'b0;
                  r_frame_done <= 1'b1;
               end else begin
                  r_idx <= r_idx - 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.word_ready = w_word_ready;
   assign bus.bit_out    = r_bit_out;
   assign bus.bit_valid  = r_bit_valid;
   assign bus.frame_busy = r_frame_busy;
   assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_tx_frame_serializer.sv
// Bench for tx_frame_serializer: directed frame scenarios followed by a random
// soak, all compared against a queue-based line model.
module tb_tx_frame_serializer;
   localparam int          DATA_W   = 16;
   localparam logic [7:0]  SYNC_PAT = 8'hD5;

   logic clk_sys = 1'b0;
   logic rst_n;
   always #5 clk_sys = ~clk_sys;

   tx_frame_if #(.DATA_W(DATA_W)) ifc ();

   tx_frame_serializer #(
      .DATA_W(DATA_W), .SYNC_W(8), .SYNC_PAT(SYNC_PAT), .IDLE_BIT(1'b0)
   ) dut (
      .clk_sys(clk_sys),
      .rst_n  (rst_n),
      .bus    (ifc)
   );

   int   checks = 0;
   int   errors = 0;
   logic line_q[$];
   logic m_q[$];
   logic m_bit = 1'b0, m_vld = 1'b0, m_busy = 1'b0, m_done = 1'b0;
   bit   chk_en = 1'b0;
   int   pace = 0;
   int   pace_cnt = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Remainder of message * x^8 divided by x^8+x^2+x+1.
   function automatic logic [7:0] ref_crc(input logic [15:0] d);
      logic [23:0] r;
      r = {d, 8'h00};
      for (int i = 23; i >= 8; i--)
         if (r[i]) r = r ^ (24'h107 << (i - 8));
      return r[7:0];
   endfunction

   function automatic logic [31:0] exp_frame(input logic [15:0] d);
      return {SYNC_PAT, d, ref_crc(d)};
   endfunction

   function automatic logic [63:0] last_bits(input int n);
      logic [63:0] r;
      r = '0;
      if (line_q.size() >= n)
         for (int i = 0; i < n; i++) r = {r[62:0], line_q[line_q.size() - n + i]};
      return r;
   endfunction

   // Line model: a frame becomes a queue of pending bits; each handshake pops one.
   always @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         m_bit = 1'b0; m_vld = 1'b0; m_busy = 1'b0; m_done = 1'b0;
      end else begin
         logic bh, acc;
         logic [31:0] fr;
         bh  = m_vld && ifc.bit_ready;
         acc = ifc.tx_en && m_vld && (m_q.size() == 0) && ifc.word_valid;
         m_done = 1'b0;
         if (!ifc.tx_en) begin
            m_q.delete();
            m_bit = 1'b0; m_vld = 1'b0; m_busy = 1'b0;
         end else begin
            if (bh) begin
               if (m_q.size() > 0) begin
                  m_bit = m_q.pop_front();
                  if (m_q.size() == 0) begin m_done = 1'b1; m_busy = 1'b0; end
               end else begin
                  m_bit = 1'b0;
               end
            end
            if (acc) begin
               fr = exp_frame(ifc.word_data);
               for (int i = 31; i >= 0; i--) m_q.push_back(fr[i]);
               m_busy = 1'b1;
            end
            m_vld = 1'b1;
         end
      end
   end

   always @(posedge clk_sys) begin
      if (rst_n && ifc.tx_en && ifc.bit_valid && ifc.bit_ready) begin
         #1 line_q.push_back(ifc.bit_out);
      end
   end

   always @(posedge clk_sys) begin
      #3;
      if (rst_n && chk_en) begin
         chk("m_bit_out",    ifc.bit_out,    m_bit);
         chk("m_bit_valid",  ifc.bit_valid,  m_vld);
         chk("m_busy",       ifc.frame_busy, m_busy);
         chk("m_done",       ifc.frame_done, m_done);
         chk("m_word_ready", ifc.word_ready, ifc.tx_en && m_vld && (m_q.size() == 0));
      end
   end

   // Advance to the next falling edge and drive bit_ready per pacing mode.
   task automatic tick();
      @(negedge clk_sys);
      pace_cnt = (pace_cnt + 1) % 4;
      case (pace)
         0:       ifc.bit_ready = (pace_cnt == 0);
         1:       ifc.bit_ready = 1'b1;
         2:       ifc.bit_ready = 1'b0;
         default: ifc.bit_ready = ($urandom_range(0, 1) == 1);
      endcase
   endtask

   task automatic send_word(input logic [15:0] d, input bit keep);
      bit got;
      got = 1'b0;
      ifc.word_data  = d;
      ifc.word_valid = 1'b1;
      for (int n = 0; n < 300 && !got; n++) begin
         if (ifc.word_ready) got = 1'b1;
         tick();
      end
      if (!keep) ifc.word_valid = 1'b0;
      if (!got) chk("accept_timeout", 1'b0, 1'b1);
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!ifc.frame_done && cyc < 400) begin
         tick();
         cyc++;
      end
      if (!ifc.frame_done) chk("done_timeout", 1'b0, 1'b1);
   endtask

   task automatic wait_bits(input int base, input int n);
      int k;
      k = 0;
      while (line_q.size() < base + n && k < 400) begin
         tick();
         k++;
      end
      if (line_q.size() < base + n) chk("bits_timeout", 1'b0, 1'b1);
   endtask

   initial begin
      int   cyc;
      int   base;
      logic hold_bit;
      rst_n          = 1'b0;
      ifc.tx_en      = 1'b0;
      ifc.word_valid = 1'b0;
      ifc.word_data  = '0;
      ifc.bit_ready  = 1'b0;
      repeat (3) tick();
      chk("rst_bit_out",    ifc.bit_out,    1'b0);
      chk("rst_bit_valid",  ifc.bit_valid,  1'b0);
      chk("rst_word_ready", ifc.word_ready, 1'b0);
      chk("rst_busy",       ifc.frame_busy, 1'b0);
      chk("rst_done",       ifc.frame_done, 1'b0);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      tick();

      // Enable with no words: idle fill only.
      ifc.tx_en = 1'b1;
      tick();
      chk("en_bit_valid",  ifc.bit_valid,  1'b1);
      chk("en_word_ready", ifc.word_ready, 1'b1);
      repeat (8) begin
         tick();
         chk("idle_bit", ifc.bit_out, 1'b0);
      end

      // Single frames at encoder pace (one handshake per 4 clocks).
      pace = 0;
      send_word(16'h00A5, 1'b0);
      wait_done(cyc);
      chk("frame_00A5", last_bits(32), {8'hD5, 16'h00A5, 8'h72});
      chk("latency_00A5", (cyc >= 125 && cyc <= 128), 1'b1);
      tick();
      chk("done_pulse", ifc.frame_done, 1'b0);
      send_word(16'h0001, 1'b0);
      wait_done(cyc);
      chk("frame_0001", last_bits(32), {8'hD5, 16'h0001, 8'h07});
      send_word(16'h0000, 1'b0);
      wait_done(cyc);
      chk("frame_0000", last_bits(32), {8'hD5, 16'h0000, 8'h00});

      // Back-to-back: second word held valid, no idle bits between frames.
      send_word(16'hBEEF, 1'b1);
      ifc.word_data = 16'h1234;
      wait_done(cyc);
      send_word(16'h1234, 1'b0);
      wait_done(cyc);
      chk("b2b_frames", last_bits(64), {exp_frame(16'hBEEF), exp_frame(16'h1234)});

      // One-cycle flush during payload bit 5.
      pace = 1;
      send_word(16'hF00D, 1'b0);
      base = line_q.size();
      wait_bits(base, 8 + 6);
      ifc.tx_en = 1'b0;
      tick();
      chk("flush_bit_valid", ifc.bit_valid,  1'b0);
      chk("flush_busy",      ifc.frame_busy, 1'b0);
      chk("flush_bit_out",   ifc.bit_out,    1'b0);
      ifc.tx_en = 1'b1;
      tick();
      send_word(16'h3C5A, 1'b0);
      wait_done(cyc);
      chk("post_flush_frame", last_bits(32), exp_frame(16'h3C5A));

      // Encoder stall mid-frame.
      pace = 0;
      send_word(16'hC3A7, 1'b0);
      base = line_q.size();
      wait_bits(base, 12);
      pace = 2;
      tick();
      hold_bit = m_bit;
      repeat (20) begin
         tick();
         chk("stall_bit_out", ifc.bit_out,    hold_bit);
         chk("stall_busy",    ifc.frame_busy, 1'b1);
      end
      pace = 0;
      wait_done(cyc);
      chk("stall_frame", last_bits(32), exp_frame(16'hC3A7));

      // Asynchronous reset in the CRC field.
      send_word(16'h5A5A, 1'b0);
      base = line_q.size();
      wait_bits(base, 27);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_bit_out",    ifc.bit_out,    1'b0);
      chk("arst_bit_valid",  ifc.bit_valid,  1'b0);
      chk("arst_word_ready", ifc.word_ready, 1'b0);
      chk("arst_busy",       ifc.frame_busy, 1'b0);
      chk("arst_done",       ifc.frame_done, 1'b0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      send_word(16'h8001, 1'b0);
      wait_done(cyc);
      chk("post_rst_frame", last_bits(32), exp_frame(16'h8001));

      // Random soak against the line model.
      pace = 3;
      repeat (3000) begin
         tick();
         ifc.tx_en      = ($urandom_range(0, 99) != 0);
         ifc.word_valid = ($urandom_range(0, 1) == 1);
         ifc.word_data  = 16'($urandom);
      end
      ifc.word_valid = 1'b0;
      tick();
      chk_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
